// File: rtl/stream_deframer.sv
// stream_deframer: finds MAGIC/LEN framed packets in a word stream, forwards the payload
// with otlast, and checks the XOR trailer, reporting frame_done/frame_err pulses.
module stream_deframer #(
    parameter int         DSIZE   = 4,
    parameter logic [7:0] MAGIC   = 8'hA5,
    parameter int         MAX_LEN = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 itvalid,
    output logic                 itready,
    input  logic [DSIZE*8-1:0]   itdata,
    output logic                 otvalid,
    input  logic                 otready,
    output logic [DSIZE*8-1:0]   otdata,
    output logic                 otlast,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic [1:0]           err_code,
    output logic [15:0]          frame_cnt
);
    localparam int W = DSIZE * 8;
    localparam logic [16:0] MAX_L = 17'(MAX_LEN);
    localparam logic [1:0] HUNT = 2'd0, PAYLOAD = 2'd1, CHECK = 2'd2;

    logic [1:0]   r_state;
    logic [15:0]  r_rem;
    logic [W-1:0] r_csum;
    logic         r_done;
    logic         r_err;
    logic [1:0]   r_code;
    logic [15:0]  r_frame_cnt;
    logic         w_pay;
    logic         w_acc;
    logic [15:0]  w_len;
    logic         w_magic_ok;
    logic         w_len_ok;

    assign w_pay      = r_state == PAYLOAD;
    // Ready is gated by rst_n so nothing is consumed while reset is held.
    assign itready    = rst_n & (w_pay ? otready : 1'b1);
    assign otvalid    = w_pay & itvalid;
    assign otdata     = w_pay ? itdata : '0;
    assign otlast     = w_pay & (r_rem == 16'd1);
    assign w_acc      = itvalid & itready;
    assign w_len      = itdata[15:0];
    assign w_magic_ok = itdata[W-1 -: 8] == MAGIC;
    assign w_len_ok   = (w_len != 16'd0) && ({1'b0, w_len} <= MAX_L);

    assign frame_done = r_done;
    assign frame_err  = r_err;
    assign err_code   = r_code;
    assign frame_cnt  = r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HUNT;
            r_rem       <= '0;
            r_csum      <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_code      <= 2'd0;
            r_frame_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                HUNT: if (w_acc) begin
                    if (!w_magic_ok) begin
                        r_err  <= 1'b1;
                        r_code <= 2'b01;
                    end else if (!w_len_ok) begin
                        r_err  <= 1'b1;
                        r_code <= 2'b10;
                    end else begin
                        r_rem   <= w_len;
                        r_csum  <= '0;
                        r_state <= PAYLOAD;
                    end
                end
                PAYLOAD: if (w_acc) begin
                    r_csum <= r_csum ^ itdata;
                    r_rem  <= r_rem - 16'd1;
                    if (r_rem == 16'd1) r_state <= CHECK;
                end
                CHECK: if (w_acc) begin
                    if (itdata == r_csum) begin
                        r_done      <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end else begin
                        r_err  <= 1'b1;
                        r_code <= 2'b11;
                    end
                    r_state <= HUNT;
                end
                default: r_state <= HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_deframer.sv
// tb_stream_deframer: scoreboard bench for stream_deframer (DSIZE=4, MAX_LEN=1024).
module tb_stream_deframer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        itvalid;
    logic        itready;
    logic [31:0] itdata;
    logic        otvalid;
    logic        otready;
    logic [31:0] otdata;
    logic        otlast;
    logic        frame_done;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [15:0] frame_cnt;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [32:0] exp_q[$];
    logic [2:0]  evt_q[$];
    logic [31:0] pl[$];
    logic [15:0] exp_cnt = 16'd0;
    logic        bp = 1'b0;
    logic        bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [32:0] mon_e;
    logic [2:0]  mon_ev;

    stream_deframer #(.DSIZE(4), .MAGIC(8'hA5), .MAX_LEN(1024)) dut (
        .clk(clk), .rst_n(rst_n), .itvalid(itvalid), .itready(itready), .itdata(itdata),
        .otvalid(otvalid), .otready(otready), .otdata(otdata), .otlast(otlast),
        .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        otready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            otready = bp ? bp_pat[$urandom_range(0, 3)] : 1'b1;
        end
    end

    // Scoreboard: outputs and pulses sampled mid-cycle, popped in order.
    always @(negedge clk) if (rst_n) begin
        if (otvalid) chk("itready_mirror", 64'(itready), 64'(otready));
        if (otvalid && otready) begin
            if (exp_q.size() == 0) chk("out_extra", 64'd1, 64'd0);
            else begin
                mon_e = exp_q.pop_front();
                chk("otdata", 64'(otdata), 64'(mon_e[31:0]));
                chk("otlast", 64'(otlast), 64'(mon_e[32]));
            end
        end
        if (frame_done || frame_err) begin
            chk("pulse_excl", 64'(frame_done & frame_err), 64'd0);
            if (evt_q.size() == 0) chk("evt_extra", 64'd1, 64'd0);
            else begin
                mon_ev = evt_q.pop_front();
                chk("event", frame_done ? 64'd4 : 64'(err_code), 64'(mon_ev));
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input int gap);
        logic ok;
        itvalid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        itvalid = 1'b1;
        itdata  = d;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = itready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        itvalid = 1'b0;
        itdata  = '0;
    endtask

    task automatic send_frame(input bit bad, input int gap);
        logic [31:0] x;
        x = '0;
        for (int i = 0; i < pl.size(); i++) begin
            exp_q.push_back({i == pl.size() - 1, pl[i]});
            x ^= pl[i];
        end
        send_word({8'hA5, 8'h00, 16'(pl.size())}, gap);
        for (int i = 0; i < pl.size(); i++) send_word(pl[i], gap);
        evt_q.push_back(bad ? 3'd3 : 3'd4);
        if (!bad) exp_cnt++;
        send_word(x ^ (bad ? 32'd1 : 32'd0), gap);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("evt_q_drained", 64'(evt_q.size()), 64'd0);
        chk("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        itvalid = 1'b0;
        itdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_itready", 64'(itready), 64'd0);
        chk("rst_otvalid", 64'(otvalid), 64'd0);
        chk("rst_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_code", 64'(err_code), 64'd0);
        chk("rst_pulses", 64'({frame_done, frame_err}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        pl = '{32'h11111111, 32'h22222222, 32'h44444444};
        send_frame(1'b0, 0);
        settle();

        bp = 1'b1;
        send_frame(1'b0, 2);
        bp = 1'b0;
        settle();

        evt_q.push_back(3'd1);
        send_word(32'h12345678, 0);
        evt_q.push_back(3'd1);
        send_word(32'hFFFFFFFF, 0);
        send_frame(1'b0, 0);
        settle();
        chk("err_code_hold", 64'(err_code), 64'd1);

        evt_q.push_back(3'd2);
        send_word(32'hA5000000, 0);
        evt_q.push_back(3'd2);
        send_word(32'hA5000401, 0);
        settle();
        chk("err_code_len", 64'(err_code), 64'd2);

        send_frame(1'b1, 0);
        settle();
        chk("err_code_csum", 64'(err_code), 64'd3);

        pl = '{32'hCAFEF00D};
        send_frame(1'b0, 0);
        pl.delete();
        for (int i = 0; i < 1024; i++) pl.push_back($urandom);
        send_frame(1'b0, 0);
        settle();

        pl = '{32'h11111111, 32'h22222222, 32'h44444444};
        exp_q.push_back({1'b0, pl[0]});
        exp_q.push_back({1'b0, pl[1]});
        send_word(32'hA5000003, 0);
        send_word(pl[0], 0);
        send_word(pl[1], 0);
        rst_n = 1'b0;
        itvalid = 1'b1;
        itdata = pl[2];
        @(negedge clk);
        chk("mid_rst_itready", 64'(itready), 64'd0);
        chk("mid_rst_otvalid", 64'(otvalid), 64'd0);
        chk("mid_rst_otlast", 64'(otlast), 64'd0);
        chk("mid_rst_otdata", 64'(otdata), 64'd0);
        chk("mid_rst_pulses", 64'({frame_done, frame_err}), 64'd0);
        chk("mid_rst_code", 64'(err_code), 64'd0);
        chk("mid_rst_cnt", 64'(frame_cnt), 64'd0);
        exp_cnt = 16'd0;
        @(posedge clk);
        #1;
        itvalid = 1'b0;
        rst_n = 1'b1;
        send_frame(1'b0, 0);
        settle();

        force dut.r_frame_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.r_frame_cnt;
        exp_cnt = 16'hFFFF;
        chk("cnt_preload", 64'(frame_cnt), 64'hFFFF);
        send_frame(1'b0, 0);
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_deframer.md
Name: stream_deframer

Overview:
- Sits directly downstream of the ftdi_245fifo user read port (otvalid/otready/otdata) and runs in the user clock domain.
- Finds framed packets in the host-to-FPGA word stream, forwards payload words with an end-of-frame marker, and checks a per-frame XOR checksum.
- Reports frame completion and errors to user logic.

Parameters:
- DSIZE, 4, word width in bytes. Legal values: 4 or 8. Must match the ftdi_245fifo OUTPUT_DSIZE.
- MAGIC, 8'hA5, header sync byte, located in the top byte of the header word.
- MAX_LEN, 1024, maximum payload length in words (1..65535).

Ports:
- clk  input  1  user clock; same clock as the ftdi_245fifo oclk.
- rst_n  input  1  asynchronous, active-low reset.
- itvalid  input  1  upstream word valid (from ftdi_245fifo otvalid).
- itready  output  1  upstream ready (to ftdi_245fifo otready).
- itdata  input  DSIZE*8  upstream word.
- otvalid  output  1  payload word valid.
- otready  input  1  downstream ready.
- otdata  output  DSIZE*8  payload word.
- otlast  output  1  high on the last payload word of a frame.
- frame_done  output  1  one-cycle pulse: checksum matched.
- frame_err  output  1  one-cycle pulse: error detected.
- err_code  output  2  valid with frame_err. 01 = bad magic, 10 = bad length, 11 = checksum mismatch. Held until the next error.
- frame_cnt  output  16  count of good frames; wraps 0xFFFF -> 0x0000.

Behaviour:
- Transfer rule: a word is accepted when itvalid & itready at a rising clk edge. The same rule applies to the output side with otvalid & otready.
- Frame format, in order:
  - Header word: bits [DSIZE*8-1 -: 8] = MAGIC; bits [15:0] = LEN; other bits ignored.
  - LEN payload words.
  - Trailer word = XOR of all payload words, full DSIZE*8 width.
- Reset (rst_n low, async): state = HUNT. itready=0, otvalid=0, otlast=0, frame_done=0, frame_err=0, err_code=0, frame_cnt=0, internal remaining-word count=0, checksum=0.
  - Reset mid-frame abandons the frame silently: no error pulse, no partial otlast.
- FSM states: HUNT, PAYLOAD, CHECK.
- HUNT:
  - itready=1, otvalid=0.
  - Accepted word with top byte != MAGIC: discard it, frame_err pulse with err_code=01, stay in HUNT. Every discarded word pulses.
  - Top byte == MAGIC and LEN==0 or LEN>MAX_LEN: frame_err pulse with err_code=10, stay in HUNT.
  - Otherwise: load rem=LEN, clear csum, go to PAYLOAD on the next cycle.
- PAYLOAD:
  - Combinational pass-through with zero latency: otvalid=itvalid, itready=otready, otdata=itdata, otlast=(rem==1).
  - On each accepted word: csum ^= itdata, rem -= 1.
  - When the word with rem==1 is accepted, go to CHECK.
  - Downstream backpressure stalls upstream 1:1. No words are dropped or duplicated.
- CHECK:
  - itready=1, otvalid=0.
  - On the accepted trailer: if trailer == csum, pulse frame_done and increment frame_cnt. Otherwise pulse frame_err with err_code=11.
  - Go to HUNT in both cases.
- Pulse timing: frame_done and frame_err are registered and asserted in the cycle after the deciding transfer. Never both high in the same cycle.
- Payload is forwarded before the checksum is known. Consumers must qualify a frame with frame_done/frame_err, which arrives on or after the first trailer transfer following otlast.
- Back-to-back frames are allowed: a header may immediately follow a trailer with no idle cycles.
- Outside PAYLOAD, otdata is don't-care; drive it 0 for waveform clarity.
- Width rules: LEN is compared unsigned. The rem counter is 16 bits. The frame_cnt increment wraps modulo 2^16.

Test Plan:
- Good frame, DSIZE=4: header 0xA5000003, payload 0x11111111, 0x22222222, 0x44444444, trailer 0x77777777, otready=1 -> 3 output words, otlast only on 0x44444444, frame_done one pulse, frame_cnt=1, frame_err never set.
- Same frame with otready toggling 1,0,0,1 and itvalid gaps -> identical otdata sequence, no drops or duplicates, itready mirrors otready only in PAYLOAD.
- Garbage 0x12345678, 0xFFFFFFFF, then the good frame -> two frame_err pulses with err_code=01, then the frame is delivered and frame_cnt=1.
- Header 0xA5000000, then header 0xA5000401 (MAX_LEN=1024) -> two err_code=10 pulses, no otvalid, state returns to HUNT.
- Good frame with trailer 0x77777776 -> 3 words forwarded with otlast, frame_err with err_code=11, frame_cnt unchanged.
- Assert rst_n low after 2 payload words, then release and send a good frame -> all outputs 0 during reset, no error pulse, next frame completes with frame_cnt=1.
- Preload frame_cnt to 0xFFFF by sending 65535 minimal 1-word frames (shortened via force in the bench), then one more good frame -> frame_cnt wraps to 0x0000.
